// File: rtl/seg_scan_decoder.sv
// Reads back a 6-digit multiplexed 7-segment display from its SEL/SEG scan lines.
// Settled digits are collected into a frame, then the frame is converted to binary, point and sign.
module seg_scan_decoder #(
  parameter logic [15:0] SETTLE_CYC  = 16'd1000,
  parameter logic [23:0] TIMEOUT_CYC = 24'd500_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  SEL,
  input  logic [7:0]  SEG,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        valid,
  output logic        err
);

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;
  localparam logic [3:0] CODE_ILL   = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;

  function automatic logic [3:0] seg_to_code(input logic [6:0] s);
    logic [3:0] c;
    case (s)
      7'b1000000: c = 4'd0;
      7'b1111001: c = 4'd1;
      7'b0100100: c = 4'd2;
      7'b0110000: c = 4'd3;
      7'b0011001: c = 4'd4;
      7'b0010010: c = 4'd5;
      7'b0000010: c = 4'd6;
      7'b1111000: c = 4'd7;
      7'b0000000: c = 4'd8;
      7'b0010000: c = 4'd9;
      7'b0111111: c = CODE_MINUS;
      7'b1111111: c = CODE_BLANK;
      default:    c = CODE_ILL;
    endcase
    return c;
  endfunction

  // Only the six single-low codes address a digit; all-high and multi-low are ignored.
  function automatic logic sel_legal(input logic [5:0] s);
    logic ok;
    case (s)
      6'b111110, 6'b111101, 6'b111011,
      6'b110111, 6'b101111, 6'b011111: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] sel_index(input logic [5:0] s);
    logic [2:0] idx;
    case (s)
      6'b111101: idx = 3'd1;
      6'b111011: idx = 3'd2;
      6'b110111: idx = 3'd3;
      6'b101111: idx = 3'd4;
      6'b011111: idx = 3'd5;
      default:   idx = 3'd0;
    endcase
    return idx;
  endfunction

  logic [5:0]  sel_q;
  logic [7:0]  seg_q;
  logic [15:0] stab_q, stab_d;
  logic        capture;
  logic        sel_ok;
  logic        changed;
  logic [2:0]  cap_idx;
  logic [3:0]  cap_code;

  always_comb begin
    sel_ok   = sel_legal(sel_q);
    cap_idx  = sel_index(sel_q);
    cap_code = seg_to_code(seg_q[6:0]);
    changed  = (SEL != sel_q) || (SEG != seg_q);
    stab_d   = stab_q;
    capture  = 1'b0;
    if (changed || !sel_ok) begin
      stab_d = '0;
    end else if (stab_q != SETTLE_CYC - 16'd1) begin
      stab_d  = stab_q + 16'd1;
      capture = (stab_q == SETTLE_CYC - 16'd2);
    end
  end

  logic [3:0] slot_code_q  [6];
  logic [3:0] slot_code_nx [6];
  logic [5:0] slot_dp_q;
  logic [5:0] slot_dp_nx;
  logic [3:0] snap_code_q  [6];
  logic [5:0] snap_dp_q;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_slot
      logic hit;
      assign hit              = capture && (cap_idx == 3'(gi));
      assign slot_code_nx[gi] = hit ? cap_code : slot_code_q[gi];
      assign slot_dp_nx[gi]   = hit ? ~seg_q[7] : slot_dp_q[gi];
    end
  endgenerate

  logic [5:0]  seen_q, seen_d;
  logic [23:0] idle_q, idle_d;
  logic        frame_start;
  state_t      state_q;

  // A full seen mask is acted on the edge after it fills; a capture on that edge still lands in the snapshot.
  always_comb begin
    seen_d      = seen_q;
    idle_d      = idle_q;
    frame_start = 1'b0;
    if (seen_q == 6'b111111) begin
      seen_d      = '0;
      idle_d      = '0;
      frame_start = (state_q == ST_IDLE);
    end else if (capture) begin
      seen_d[cap_idx] = 1'b1;
      idle_d          = '0;
    end else if (seen_q == 6'b000000) begin
      idle_d = '0;
    end else if (idle_q == TIMEOUT_CYC - 24'd1) begin
      seen_d = '0;
      idle_d = '0;
    end else begin
      idle_d = idle_q + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q     <= 6'b111111;
      seg_q     <= 8'hFF;
      stab_q    <= '0;
      seen_q    <= '0;
      idle_q    <= '0;
      slot_dp_q <= '0;
      snap_dp_q <= '0;
      for (int i = 0; i < 6; i++) begin
        slot_code_q[i] <= CODE_BLANK;
        snap_code_q[i] <= CODE_BLANK;
      end
    end else begin
      sel_q     <= SEL;
      seg_q     <= SEG;
      stab_q    <= stab_d;
      seen_q    <= seen_d;
      idle_q    <= idle_d;
      slot_dp_q <= slot_dp_nx;
      for (int i = 0; i < 6; i++) begin
        slot_code_q[i] <= slot_code_nx[i];
      end
      if (frame_start) begin
        snap_dp_q <= slot_dp_nx;
        for (int i = 0; i < 6; i++) begin
          snap_code_q[i] <= slot_code_nx[i];
        end
      end
    end
  end

  logic [2:0]  idx_q;
  logic [19:0] acc_q;
  logic [19:0] acc_next;
  logic        sign_acc_q, err_acc_q;
  logic [3:0]  cur_code;
  logic [3:0]  dig_val;
  logic        dig_sign, dig_err;
  logic [19:0] data_q;
  logic [5:0]  point_q;
  logic        sign_q, valid_q, err_q;

  // Minus is a sign only in the leading position; blank reads as zero.
  always_comb begin
    cur_code = snap_code_q[idx_q];
    dig_val  = 4'd0;
    dig_sign = 1'b0;
    dig_err  = 1'b0;
    if (cur_code <= 4'd9) begin
      dig_val = cur_code;
    end else if (cur_code == CODE_MINUS) begin
      if (idx_q == 3'd5) dig_sign = 1'b1;
      else               dig_err  = 1'b1;
    end else if (cur_code != CODE_BLANK) begin
      dig_err = 1'b1;
    end
    acc_next = (acc_q << 3) + (acc_q << 1) + {16'd0, dig_val};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      sign_acc_q <= 1'b0;
      err_acc_q  <= 1'b0;
      data_q     <= '0;
      point_q    <= '0;
      sign_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q    <= ST_CONV;
            idx_q      <= 3'd5;
            acc_q      <= '0;
            sign_acc_q <= 1'b0;
            err_acc_q  <= 1'b0;
          end
        end
        ST_CONV: begin
          acc_q      <= acc_next;
          sign_acc_q <= sign_acc_q | dig_sign;
          err_acc_q  <= err_acc_q | dig_err;
          if (idx_q == 3'd0) state_q <= ST_DONE;
          else               idx_q   <= idx_q - 3'd1;
        end
        ST_DONE: begin
          data_q  <= acc_q;
          point_q <= snap_dp_q;
          sign_q  <= sign_acc_q;
          err_q   <= err_acc_q;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data  = data_q;
  assign point = point_q;
  assign sign  = sign_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives scan frames on SEL/SEG and checks decoded outputs.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  SEL;
  logic [7:0]  SEG;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        valid;
  logic        err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcount = 0;
  int vat    = 0;
  int t_last = 0;
  int base;
  logic [19:0] vdata = '0;
  logic [19:0] prev_vdata = '0;

  seg_scan_decoder #(
    .SETTLE_CYC  (16'd4),
    .TIMEOUT_CYC (24'd64)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .SEL   (SEL),
    .SEG   (SEG),
    .data  (data),
    .point (point),
    .sign  (sign),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcount     = vcount + 1;
      prev_vdata = vdata;
      vdata      = data;
      vat        = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // 0..9 digits, 10 = minus, 11 = illegal pattern 1010101, 12 = blank
  function automatic logic [7:0] enc(input logic [3:0] d, input logic dp);
    logic [6:0] s;
    case (d)
      4'd0:  s = 7'b1000000;
      4'd1:  s = 7'b1111001;
      4'd2:  s = 7'b0100100;
      4'd3:  s = 7'b0110000;
      4'd4:  s = 7'b0011001;
      4'd5:  s = 7'b0010010;
      4'd6:  s = 7'b0000010;
      4'd7:  s = 7'b1111000;
      4'd8:  s = 7'b0000000;
      4'd9:  s = 7'b0010000;
      4'd10: s = 7'b0111111;
      4'd11: s = 7'b1010101;
      default: s = 7'b1111111;
    endcase
    return {~dp, s};
  endfunction

  function automatic logic [47:0] mk(input logic [23:0] bcd, input logic [5:0] dp);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[8*i +: 8] = enc(bcd[4*i +: 4], dp[i]);
    return r;
  endfunction

  task automatic scan(input logic [47:0] segs, input logic [5:0] mask, input int dwell);
    for (int i = 0; i < 6; i++) begin
      if (mask[i]) begin
        @(negedge clk);
        SEL    = ~(6'd1 << i);
        SEG    = segs[8*i +: 8];
        t_last = cyc;
        repeat (dwell - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    SEL = 6'b111111;
    SEG = 8'hFF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int target);
    for (int k = 0; k < 60 && vcount < target; k++) @(negedge clk);
    idle(1);
  endtask

  initial begin
    rstn = 1'b0;
    SEL  = 6'b111111;
    SEG  = 8'hFF;
    idle(3);
    check("rst_data", 32'(data), 0);
    check("rst_point", 32'(point), 0);
    check("rst_sign", 32'(sign), 0);
    check("rst_err", 32'(err), 0);
    check("rst_valid", 32'(valid), 0);
    rstn = 1'b1;
    idle(2);

    scan(mk(24'h123456, 6'b000100), 6'b111111, 6);
    wait_valid(1);
    check("f1_vcnt", vcount, 1);
    check("f1_data", 32'(data), 123456);
    check("f1_point", 32'(point), 32'b000100);
    check("f1_sign", 32'(sign), 0);
    check("f1_err", 32'(err), 0);
    check("f1_latency", vat - t_last, 12);

    scan(mk(24'hA12345, 6'b000000), 6'b111111, 6);
    wait_valid(2);
    check("neg_vcnt", vcount, 2);
    check("neg_data", 32'(data), 12345);
    check("neg_sign", 32'(sign), 1);
    check("neg_err", 32'(err), 0);

    scan(mk(24'h999999, 6'b000000), 6'b111111, 6);
    scan(mk(24'h000000, 6'b000000), 6'b111111, 6);
    wait_valid(4);
    idle(15);
    check("b2b_vcnt", vcount, 4);
    check("b2b_first", 32'(prev_vdata), 999999);
    check("b2b_second", 32'(vdata), 0);

    scan(mk(24'h12B456, 6'b000000), 6'b111111, 6);
    wait_valid(5);
    check("ill_data", 32'(data), 120456);
    check("ill_err", 32'(err), 1);
    check("ill_sign", 32'(sign), 0);

    scan(mk(24'hA8A912, 6'b000001), 6'b111111, 6);
    wait_valid(6);
    check("m3_data", 32'(data), 80912);
    check("m3_err", 32'(err), 1);
    check("m3_sign", 32'(sign), 1);
    check("m3_point", 32'(point), 1);

    // Reset lands while the frame is being converted.
    base = vcount;
    scan(mk(24'h111111, 6'b000000), 6'b111111, 6);
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(20);
    check("rc_vcnt", vcount, base);
    check("rc_data", 32'(data), 0);
    check("rc_point", 32'(point), 0);
    check("rc_sign", 32'(sign), 0);
    check("rc_err", 32'(err), 0);

    scan(mk(24'h246813, 6'b100001), 6'b111111, 6);
    wait_valid(base + 1);
    check("post_vcnt", vcount, base + 1);
    check("post_data", 32'(data), 246813);
    check("post_point", 32'(point), 32'b100001);

    // Dwell one cycle short, then all-high and double-low selects.
    base = vcount;
    scan(mk(24'h111111, 6'b000000), 6'b111111, 3);
    SEL = 6'b111111; SEG = enc(4'd8, 1'b0);
    idle(12);
    SEL = 6'b111100;
    idle(12);
    SEL = 6'b111111; SEG = 8'hFF;
    idle(20);
    check("nocap_vcnt", vcount, base);
    check("nocap_err", 32'(err), 0);

    // Partial frame expires; the remaining half alone must not complete a frame.
    scan(mk(24'h654321, 6'b000000), 6'b000111, 6);
    idle(80);
    scan(mk(24'h654321, 6'b000000), 6'b111000, 6);
    idle(25);
    check("to_vcnt", vcount, base);
    idle(80);
    scan(mk(24'h654321, 6'b000000), 6'b000111, 6);
    idle(40);
    scan(mk(24'h654321, 6'b000000), 6'b111000, 6);
    wait_valid(base + 1);
    check("to_ok_vcnt", vcount, base + 1);
    check("to_ok_data", 32'(data), 654321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
